instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 24 ++
 rtl/byte_assembler.sv | 44 ++++
 rtl/instr_loader.sv | 109 ++++++++++
 tb/tb_instr_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: default memory width,
// FSM state encoding and the little-endian byte shift helper.
package instr_loader_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    // Byte index of the most significant byte within a 32-bit word.
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_t;

    // New bytes enter at the top, so after four shifts the first byte sits in bits 7:0.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  data);
        return {data, word[31:8]};
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects host bytes into little-endian 32-bit words and keeps a running
// XOR checksum of every data byte it accepts.
module byte_assembler
    import instr_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_signal,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte,
    output logic [7:0]  checksum
);

    logic [1:0]  byte_idx_reg;
    logic [31:0] shift_reg;
    logic        word_valid_reg;
    logic [7:0]  checksum_reg;

    always_ff @(posedge clock) begin
        if (reset_signal || clear) begin
            byte_idx_reg   <= 2'd0;
            shift_reg      <= 32'd0;
            word_valid_reg <= 1'b0;
            checksum_reg   <= 8'd0;
        end else begin
            // Pulses in the cycle after the byte that completes a word.
            word_valid_reg <= byte_en && (byte_idx_reg == LAST_BYTE_IDX);
            if (byte_en) begin
                shift_reg    <= shift_in_byte(shift_reg, byte_data);
                byte_idx_reg <= byte_idx_reg + 2'd1;
                checksum_reg <= checksum_reg ^ byte_data;
            end
        end
    end

    assign word       = shift_reg;
    assign word_valid = word_valid_reg;
    assign last_byte  = (byte_idx_reg == LAST_BYTE_IDX);
    assign checksum   = checksum_reg;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: streams a host byte stream into instruction memory, verifies
// a trailing XOR checksum and releases the processor only on success.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_signal,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_busy,
    output logic              load_error
);

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t   state_reg;
    loader_state_t   state_next;
    logic [ADDR_W:0] word_cnt_reg;
    logic [ADDR_W:0] last_idx_reg;

    logic        handshake;
    logic        can_start;
    logic        len_ok;
    logic        start_accept;
    logic        data_byte_en;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic        asm_last_byte;
    logic [7:0]  asm_checksum;

    assign byte_ready   = (state_reg == ST_RECV) || (state_reg == ST_CHECK);
    assign load_busy    = byte_ready;
    assign cpu_run      = (state_reg == ST_DONE);
    assign load_error   = (state_reg == ST_ERR);
    assign handshake    = byte_valid && byte_ready;
    assign can_start    = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                          (state_reg == ST_ERR);
    assign len_ok       = (load_len != '0) && (load_len <= LEN_MAX);
    assign start_accept = can_start && load_start && len_ok;
    // The checksum byte itself never reaches the assembler.
    assign data_byte_en = handshake && (state_reg == ST_RECV);

    byte_assembler u_byte_assembler (
        .clock        (clock),
        .reset_signal (reset_signal),
        .clear        (start_accept),
        .byte_en      (data_byte_en),
        .byte_data    (byte_data),
        .word         (asm_word),
        .word_valid   (asm_word_valid),
        .last_byte    (asm_last_byte),
        .checksum     (asm_checksum)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_next = len_ok ? ST_RECV : ST_ERR;
                end
            end
            ST_RECV: begin
                if (data_byte_en && asm_last_byte && (word_cnt_reg == last_idx_reg)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (handshake) begin
                    state_next = (byte_data == asm_checksum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The counter advances after each write; the next word needs at least
    // four more handshakes, so it always reflects the word being assembled.
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            last_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                word_cnt_reg <= '0;
                last_idx_reg <= load_len - LEN_ONE;
            end else if (asm_word_valid) begin
                word_cnt_reg <= word_cnt_reg + LEN_ONE;
            end
        end
    end

    assign imem_we    = asm_word_valid;
    assign imem_addr  = word_cnt_reg[ADDR_W-1:0];
    assign imem_wdata = asm_word;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: fixed vector table, reset and
// mid-load corner sequences, and randomized loads against a stream model.
module tb_instr_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_signal = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          load_busy;
    logic          load_error;

    always #5 clock = ~clock;

    instr_loader #(.ADDR_W(AW)) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .load_start   (load_start),
        .load_len     (load_len),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .load_busy    (load_busy),
        .load_error   (load_error)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [7:0]    tx_bytes[$];

    always @(negedge clock) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    typedef struct {
        logic [AW:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  ck;
        int          gap;
        bit          mid;
        bit          exp_run;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: actual=0 required=1");
            byte_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 byte_valid = 1'b0;
    endtask

    // Drives one load from tx_bytes (data only) plus ck, then compares writes
    // against the little-endian words the stream describes.
    task automatic do_load(input logic [AW:0] len, input logic [7:0] ck, input int gap,
                           input bit mid, input bit exp_run, input bit exp_err);
        bit          valid;
        int          nexp;
        int          n;
        logic [31:0] exp_word;
        got_addr.delete();
        got_data.delete();
        valid = (len >= 1) && (len <= DEPTH);
        nexp  = valid ? int'(len) : 0;
        @(negedge clock);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clock);
        load_start = 1'b0;
        chk("busy_after_start", load_busy, valid);
        chk("error_after_start", load_error, !valid);
        if (valid) begin
            for (int k = 0; k < tx_bytes.size(); k++) begin
                if (mid && k == 2) begin
                    load_start = 1'b1;
                    load_len   = len + 3;
                end
                send_byte(tx_bytes[k], gap);
                load_start = 1'b0;
            end
            send_byte(ck, gap);
        end
        repeat (3) @(negedge clock);
        chk("write_count", got_addr.size(), nexp);
        n = (got_addr.size() < nexp) ? got_addr.size() : nexp;
        for (int w = 0; w < n; w++) begin
            exp_word = 32'(tx_bytes[4*w]) + (32'(tx_bytes[4*w+1]) << 8) +
                       (32'(tx_bytes[4*w+2]) << 16) + (32'(tx_bytes[4*w+3]) << 24);
            chk("write_addr", got_addr[w], w);
            chk("write_data", got_data[w], exp_word);
        end
        chk("cpu_run", cpu_run, exp_run);
        chk("load_error", load_error, exp_err);
        chk("load_busy_end", load_busy, 1'b0);
        chk("byte_ready_end", byte_ready, 1'b0);
        $display("load len=%0d gap=%0d mid=%0d writes=%0d cpu_run=%0d load_error=%0d",
                 len, gap, mid, got_addr.size(), cpu_run, load_error);
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_bytes.push_back(w[7:0]);
        tx_bytes.push_back(w[15:8]);
        tx_bytes.push_back(w[23:16]);
        tx_bytes.push_back(w[31:24]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW:0] rlen;
        logic [7:0]  ck;
        bit          good;

        vecs[0] = '{len: 2,  w0: 32'h13,       w1: 32'h21,       ck: 8'h32, gap: 0, mid: 0, exp_run: 1, exp_err: 0};
        vecs[1] = '{len: 2,  w0: 32'h13,       w1: 32'h21,       ck: 8'h33, gap: 0, mid: 0, exp_run: 0, exp_err: 1};
        vecs[2] = '{len: 0,  w0: 32'h0,        w1: 32'h0,        ck: 8'h00, gap: 0, mid: 0, exp_run: 0, exp_err: 1};
        vecs[3] = '{len: 17, w0: 32'h0,        w1: 32'h0,        ck: 8'h00, gap: 0, mid: 0, exp_run: 0, exp_err: 1};
        vecs[4] = '{len: 1,  w0: 32'h04030201, w1: 32'h0,        ck: 8'h04, gap: 1, mid: 0, exp_run: 1, exp_err: 0};
        vecs[5] = '{len: 2,  w0: 32'hdeadbeef, w1: 32'h01234567, ck: 8'h22, gap: 0, mid: 1, exp_run: 1, exp_err: 0};

        repeat (3) @(negedge clock);
        chk("reset_byte_ready", byte_ready, 1'b0);
        chk("reset_imem_we", imem_we, 1'b0);
        chk("reset_imem_addr", imem_addr, 0);
        chk("reset_imem_wdata", imem_wdata, 32'h0);
        chk("reset_cpu_run", cpu_run, 1'b0);
        chk("reset_load_busy", load_busy, 1'b0);
        chk("reset_load_error", load_error, 1'b0);
        reset_signal = 1'b0;

        for (int v = 0; v < 6; v++) begin
            tx_bytes.delete();
            if (vecs[v].len >= 1 && vecs[v].len <= 2) push_word(vecs[v].w0);
            if (vecs[v].len == 2) push_word(vecs[v].w1);
            do_load(vecs[v].len, vecs[v].ck, vecs[v].gap, vecs[v].mid,
                    vecs[v].exp_run, vecs[v].exp_err);
        end

        // Reset after six bytes of a four-word load.
        got_addr.delete();
        got_data.delete();
        @(negedge clock);
        load_start = 1'b1;
        load_len   = 5'd4;
        @(negedge clock);
        load_start = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(8'(8'h10 + k), 0);
        @(negedge clock);
        reset_signal = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset_byte_ready", byte_ready, 1'b0);
        chk("midreset_imem_we", imem_we, 1'b0);
        chk("midreset_imem_addr", imem_addr, 0);
        chk("midreset_imem_wdata", imem_wdata, 32'h0);
        chk("midreset_cpu_run", cpu_run, 1'b0);
        chk("midreset_load_busy", load_busy, 1'b0);
        chk("midreset_load_error", load_error, 1'b0);
        @(negedge clock);
        reset_signal = 1'b0;
        repeat (6) @(negedge clock);
        chk("midreset_writes", got_addr.size(), 1);
        if (got_data.size() > 0) chk("midreset_word0", got_data[0], 32'h13121110);
        $display("midreset writes=%0d cpu_run=%0d", got_addr.size(), cpu_run);

        // Randomized loads checked against the stream model.
        for (int r = 0; r < 8; r++) begin
            rlen = (r == 0) ? (AW+1)'(DEPTH) : (AW+1)'($urandom_range(1, DEPTH));
            tx_bytes.delete();
            ck = 8'd0;
            for (int k = 0; k < 4 * int'(rlen); k++) begin
                tx_bytes.push_back(8'($urandom_range(0, 255)));
                ck = ck ^ tx_bytes[k];
            end
            good = ($urandom_range(0, 3) != 0);
            if (!good) ck = ck ^ 8'($urandom_range(1, 255));
            do_load(rlen, ck, $urandom_range(0, 2), 1'b0, good, !good);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
